// File: rtl/output_store_control.sv
// Output-store sequencer: reads one systolic-array sub-tile from the accumulator row by row and
// issues per-column bank writes RD_LATENCY cycles later. Optional macro ACCUM_CLEAR_EN adds clear_after/accum_clear.
module output_store_control #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 1,
    localparam int NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
    localparam int SM_W = (NUM_SUBMATS_M > 1) ? $clog2(NUM_SUBMATS_M) : 1,
    localparam int SN_W = (NUM_SUBMATS_N > 1) ? $clog2(NUM_SUBMATS_N) : 1,
    localparam int NR_W = $clog2(SYS_ARR_ROWS) + 1,
    localparam int NC_W = $clog2(SYS_ARR_COLS) + 1,
    localparam int AR_W = (NUM_ACCUM_ROWS > 1) ? $clog2(NUM_ACCUM_ROWS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stall,
    input  logic [SM_W-1:0]                  submat_row_in,
    input  logic [SN_W-1:0]                  submat_col_in,
    input  logic [NR_W-1:0]                  num_rows_read,
    input  logic [NC_W-1:0]                  num_cols_read,
    input  logic                             activate,
    input  logic [ADDR_WIDTH-1:0]            wr_base_addr,
    input  logic [ADDR_WIDTH-1:0]            addr_stride,
`ifdef ACCUM_CLEAR_EN
    input  logic                             clear_after,
    output logic                             accum_clear,
`endif
    output logic                             busy,
    output logic                             done,
    output logic [SM_W-1:0]                  submat_row_out,
    output logic [SN_W-1:0]                  submat_col_out,
    output logic                             accum_rd_en,
    output logic [AR_W-1:0]                  accum_rd_row,
    output logic                             relu_en,
    output logic [SYS_ARR_COLS-1:0]          wr_en,
    output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                               state_q;
    logic [NR_W-1:0]                      r_q, nrows_q;
    logic [NC_W-1:0]                      ncols_q;
    logic                                 act_q;
    logic [AR_W-1:0]                      base_row_q;
    logic [ADDR_WIDTH-1:0]                waddr_q, stride_q;
    logic [SM_W-1:0]                      srow_q;
    logic [SN_W-1:0]                      scol_q;
    logic [RD_LATENCY-1:0]                vld_pipe_q;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] addr_pipe_q;
`ifdef ACCUM_CLEAR_EN
    logic                                 clear_q;
`endif

    logic rd_fire, wr_fire, pipe_tail_empty;
    logic [AR_W-1:0] start_row_base;

    assign rd_fire = (state_q == S_READ) && !stall;
    assign wr_fire = vld_pipe_q[RD_LATENCY-1] && !stall;
    assign start_row_base = AR_W'(int'(submat_col_in) * MAX_OUT_ROWS + int'(submat_row_in) * SYS_ARR_ROWS);

    // The last stage empties on the current shift, so only the earlier stages decide drain completion.
    always_comb begin
        pipe_tail_empty = 1'b1;
        for (int i = 0; i < RD_LATENCY - 1; i++)
            if (vld_pipe_q[i]) pipe_tail_empty = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            nrows_q     <= '0;
            ncols_q     <= '0;
            act_q       <= 1'b0;
            base_row_q  <= '0;
            waddr_q     <= '0;
            stride_q    <= '0;
            srow_q      <= '0;
            scol_q      <= '0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
`ifdef ACCUM_CLEAR_EN
            clear_q     <= 1'b0;
`endif
        end else if (!stall) begin
            vld_pipe_q[0]  <= rd_fire;
            addr_pipe_q[0] <= waddr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
            case (state_q)
                S_IDLE: if (start) begin
                    r_q        <= '0;
                    nrows_q    <= num_rows_read;
                    ncols_q    <= num_cols_read;
                    act_q      <= activate;
                    base_row_q <= start_row_base;
                    waddr_q    <= wr_base_addr;
                    stride_q   <= addr_stride;
                    srow_q     <= submat_row_in;
                    scol_q     <= submat_col_in;
`ifdef ACCUM_CLEAR_EN
                    clear_q    <= clear_after;
`endif
                    state_q    <= (num_rows_read == '0 || num_cols_read == '0) ? S_DONE : S_READ;
                end
                S_READ: begin
                    r_q     <= r_q + NR_W'(1);
                    waddr_q <= waddr_q + stride_q;
                    if (r_q == nrows_q - NR_W'(1)) state_q <= S_DRAIN;
                end
                S_DRAIN: if (pipe_tail_empty) state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE) && !stall;
    assign submat_row_out = srow_q;
    assign submat_col_out = scol_q;
    assign accum_rd_en    = rd_fire;
    assign accum_rd_row   = rd_fire ? base_row_q + AR_W'(r_q) : '0;
    assign relu_en        = wr_fire && act_q;
`ifdef ACCUM_CLEAR_EN
    assign accum_clear    = wr_fire && clear_q;
`endif

    // All lanes share one row address; lanes past the column count stay disabled.
    for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_lane
        assign wr_en[c] = wr_fire && (NC_W'(c) < ncols_q);
        assign wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = wr_fire ? addr_pipe_q[RD_LATENCY-1] : '0;
    end

endmodule
